serial_add_ctrl: RTL



---
 rtl/alu_pkg.sv | 22 ++
 rtl/serial_add_ctrl_fa.sv | 20 ++
 rtl/serial_add_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// +-----------------------------------------------------------------------+
// | alu_pkg: shared types and flag indices for the serial add path.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_fa.sv
// +-----------------------------------------------------------------------+
// | fullAdder: 1-bit full-adder cell used by the bit-serial sequencer.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module fullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// +-----------------------------------------------------------------------+
// | serial_add_ctrl: bit-serial add/subtract sequencer with NZCV flags.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       flags
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  serial_state_t    r_state;
  serial_state_t    w_next;

  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;

  logic             w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_final;
  logic [3:0]       w_flags;

  fullAdder u_fa (
    .A    (r_opA[0]),
    .B    (r_opB[0]),
    .Cin  (r_carry),
    .Sum  (w_sum),
    .Cout (w_cout)
  );

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_final  = {w_sum, r_res[WIDTH-1:1]};

  // On the last bit r_carry is the carry into the MSB, so V needs no extra register.
  always_comb begin
    w_flags         = 4'b0000;
    w_flags[FLAG_N] = w_sum;
    w_flags[FLAG_Z] = (w_final == '0);
    w_flags[FLAG_C] = w_cout;
    w_flags[FLAG_V] = r_carry ^ w_cout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opA    <= '0;
      r_opB    <= '0;
      r_res    <= '0;
      r_result <= '0;
      r_flags  <= 4'b0000;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
    end else if (w_accept) begin
      r_opA   <= A;
      r_opB   <= B ^ {WIDTH{sub}};
      r_carry <= sub;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (r_state == RUN) begin
      r_opA   <= r_opA >> 1;
      r_opB   <= r_opB >> 1;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      r_res   <= w_final;
      if (w_last) begin
        r_result <= w_final;
        r_flags  <= w_flags;
      end
    end
  end

  assign Result = r_result;
  assign flags  = r_flags;

endmodule

`default_nettype wire
